multi_bank_buffer: RTL

- Parametrised successor to the weight/input double buffer: NUM_BANKS SRAM-style banks arranged as a ring, with independent write-bank and read-bank pointers.
- Producer side (tile loader) fills a bank, then commits it. Consumer side (systolic array feeder) reads committed banks, then releases them.
- Explicit commit/release handshake replaces the single switch_banks pulse. This allows more than two tiles in flight, with full/empty back-pressure.

---
 rtl/multi_bank_buffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multi_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module   : multi_bank_buffer
// Purpose  : Ring of NUM_BANKS SRAM-style banks between a tile loader
//            (producer) and a systolic-array feeder (consumer). The producer
//            fills the bank at wr_bank_idx and commits it. The consumer reads
//            the bank at rd_bank_idx and releases it. The count of committed
//            banks gives full/empty back-pressure.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            wen/wadr/wdata   - write into current write bank
//            wcommit          - hand current write bank to the reader
//            wready           - a free bank is available to the writer
//            ren/radr         - read from current read bank (1-cycle latency)
//            rrelease         - reader done with current read bank
//            rbank_valid      - at least one committed bank is readable
//            rdata/rdata_valid- registered read data and its qualifier
//            wr_bank_idx, rd_bank_idx - current bank pointers
//            err_status[3:0]  - sticky error flags (optional, see below)
// Options  : define MULTI_BANK_BUFFER_ERR_STATUS_EN to add err_status
// Revision : 1.0 - initial release
// ============================================================================
module multi_bank_buffer #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 10,
  parameter int BANK_DEPTH      = 288,
  parameter int NUM_BANKS       = 3,
  parameter int BANK_SEL_WIDTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wen,
  input  logic [BANK_ADDR_WIDTH-1:0] wadr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       wcommit,
  output logic                       wready,
  input  logic                       ren,
  input  logic [BANK_ADDR_WIDTH-1:0] radr,
  input  logic                       rrelease,
  output logic                       rbank_valid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rdata_valid,
  output logic [BANK_SEL_WIDTH-1:0]  wr_bank_idx,
  output logic [BANK_SEL_WIDTH-1:0]  rd_bank_idx
`ifdef MULTI_BANK_BUFFER_ERR_STATUS_EN
  ,
  output logic [3:0]                 err_status
`endif
);

  // All banks live in one flat array; a bank occupies BANK_DEPTH
  // consecutive words starting at bank_index*BANK_DEPTH.
  localparam int unsigned c_mem_depth = NUM_BANKS * BANK_DEPTH;
  localparam int unsigned c_mem_aw    = (c_mem_depth > 1) ? $clog2(c_mem_depth) : 1;
  localparam logic [BANK_SEL_WIDTH:0]  c_full      = (BANK_SEL_WIDTH + 1)'(NUM_BANKS);
  localparam logic [BANK_SEL_WIDTH-1:0] c_last_bank = BANK_SEL_WIDTH'(NUM_BANKS - 1);
  // One extra bit so BANK_DEPTH == 2**BANK_ADDR_WIDTH is still representable.
  localparam logic [BANK_ADDR_WIDTH:0] c_depth     = (BANK_ADDR_WIDTH + 1)'(BANK_DEPTH);

  logic [DATA_WIDTH-1:0]     r_mem [c_mem_depth];
  logic [BANK_SEL_WIDTH-1:0] r_wr_ptr;
  logic [BANK_SEL_WIDTH-1:0] r_rd_ptr;
  logic [BANK_SEL_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_rdata_valid;

  logic                      w_wready;
  logic                      w_rvalid;
  logic                      w_wadr_ok;
  logic                      w_radr_ok;
  logic                      w_wr_acc;
  logic                      w_commit_acc;
  logic                      w_rd_acc;
  logic                      w_release_acc;
  logic [c_mem_aw-1:0]       w_wflat;
  logic [c_mem_aw-1:0]       w_rflat;

  assign w_wready  = (r_count != c_full);
  assign w_rvalid  = (r_count != '0);
  assign w_wadr_ok = ({1'b0, wadr} < c_depth);
  assign w_radr_ok = ({1'b0, radr} < c_depth);

  // Memory has no reset branch, so the write strobe itself is gated by rst_n.
  assign w_wr_acc      = rst_n & wen & w_wready & w_wadr_ok;
  assign w_commit_acc  = wcommit & w_wready;
  assign w_rd_acc      = ren & w_rvalid & w_radr_ok;
  assign w_release_acc = rrelease & w_rvalid;

  // Writes use the pre-commit pointer, reads the pre-release pointer, so a
  // same-cycle write/commit or read/release touches the old bank.
  assign w_wflat = c_mem_aw'(32'(r_wr_ptr) * BANK_DEPTH) + c_mem_aw'(wadr);
  assign w_rflat = c_mem_aw'(32'(r_rd_ptr) * BANK_DEPTH) + c_mem_aw'(radr);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wflat] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      if (w_commit_acc) begin
        r_wr_ptr <= (r_wr_ptr == c_last_bank) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_release_acc) begin
        r_rd_ptr <= (r_rd_ptr == c_last_bank) ? '0 : r_rd_ptr + 1'b1;
      end
      // When full, commit is blocked by wready, so a simultaneous release
      // lowers the count; when both are taken the count is unchanged.
      case ({w_commit_acc, w_release_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rdata_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata <= r_mem[w_rflat];
      end
    end
  end

`ifdef MULTI_BANK_BUFFER_ERR_STATUS_EN
  logic [3:0] r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err <= r_err | {ren & ~w_radr_ok,
                        wen & ~w_wadr_ok,
                        (ren | rrelease) & ~w_rvalid,
                        (wen | wcommit) & ~w_wready};
    end
  end

  assign err_status = r_err;
`endif

  assign wready      = w_wready;
  assign rbank_valid = w_rvalid;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign wr_bank_idx = r_wr_ptr;
  assign rd_bank_idx = r_rd_ptr;

endmodule
`default_nettype wire
